// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, one frame at a time.
// A byte is accepted when i_tx_valid is high in IDLE, and the start bit
// is driven from that same edge. All outputs come straight from flops,
// so the serial line cannot glitch.
module uart_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clock,
  input  logic       i_reset_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx_serial,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             serial_q, serial_d;
  logic             done_q, done_d;
  logic             ready_q, busy_q;
  logic             accept_s, bit_end_s;

  assign accept_s  = (state_q == IDLE) && i_tx_valid;
  assign bit_end_s = (cnt_q == CNT_LAST);

  // State and datapath registers; reset forces an idle-high line at once.
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      done_q   <= done_d;
      ready_q  <= (state_d == IDLE);
      busy_q   <= (state_d != IDLE);
    end
  end

  // Next-state logic: advance one phase of the frame per completed bit time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = START;
        else          state_d = IDLE;
      end
      START: begin
        if (bit_end_s) state_d = DATA;
        else           state_d = START;
      end
      DATA: begin
        if (bit_end_s && (bit_q == 3'd7)) state_d = STOP;
        else                              state_d = DATA;
      end
      STOP: begin
        if (bit_end_s) state_d = IDLE;
        else           state_d = STOP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: the line value for the next bit is chosen on the
  // bit boundary, so o_tx_serial changes exactly once per bit time.
  always_comb begin
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = 3'd0;
        if (accept_s) begin
          shift_d  = i_tx_data;
          serial_d = 1'b0;
        end else begin
          serial_d = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_d    = '0;
          serial_d = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            bit_d    = 3'd0;
            serial_d = 1'b1;
          end else begin
            bit_d    = bit_q + 3'd1;
            serial_d = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_d    = '0;
          serial_d = 1'b1;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d    = '0;
        bit_d    = 3'd0;
        shift_d  = 8'h00;
        serial_d = 1'b1;
      end
    endcase
  end

  assign o_tx_ready  = ready_q;
  assign o_tx_busy   = busy_q;
  assign o_tx_serial = serial_q;
  assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx with a byte scoreboard.
// Instance a runs at 4 clocks per bit, instance b at the default 104.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic       valid_a = 1'b0;
  logic       ready_a, serial_a, busy_a, done_a;
  logic [7:0] data_b = 8'h00;
  logic       valid_b = 1'b0;
  logic       ready_b, serial_b, busy_b, done_b;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] sb[$];

  uart_tx #(.CLKS_PER_BIT(4)) dut_a (
    .clock(clk), .i_reset_n(rst_n), .i_tx_data(data_a), .i_tx_valid(valid_a),
    .o_tx_ready(ready_a), .o_tx_serial(serial_a), .o_tx_busy(busy_a), .o_tx_done(done_a)
  );

  uart_tx dut_b (
    .clock(clk), .i_reset_n(rst_n), .i_tx_data(data_b), .i_tx_valid(valid_b),
    .o_tx_ready(ready_b), .o_tx_serial(serial_b), .o_tx_busy(busy_b), .o_tx_done(done_b)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used to measure frame spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a byte on instance a, wait (bounded) for the accepting edge, record it.
  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    valid_a = 1'b1;
    data_a  = d;
    while (!ready_a && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("accept_timeout", 32'd0, 32'd1);
    tick();
    sb.push_back(d);
    valid_a = 1'b0;
    data_a  = 8'($urandom);
  endtask

  // Observe one frame starting at the sample right after the accepting edge.
  // At cycle 'poke' a second byte (0x3C) is offered for one cycle.
  task automatic watch_frame(input int poke);
    logic [7:0] expb;
    logic [9:0] bits;
    logic [7:0] got;
    got = 8'h00;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      expb = 8'h00;
    end else begin
      expb = sb.pop_front();
    end
    bits = {1'b1, expb, 1'b0};
    for (int k = 0; k < 40; k++) begin
      if (k == poke) begin
        data_a  = 8'h3C;
        valid_a = 1'b1;
      end else if (k == poke + 1) begin
        valid_a = 1'b0;
      end
      chk($sformatf("serial_k%0d", k), serial_a, bits[k/4]);
      chk("busy_in_frame", busy_a, 1'b1);
      chk("done_in_frame", done_a, 1'b0);
      if ((k % 4 == 2) && (k >= 6) && (k < 36)) got[k/4 - 1] = serial_a;
      tick();
    end
    chk("byte", got, expb);
    chk("done_pulse", done_a, 1'b1);
    chk("busy_end", busy_a, 1'b0);
    chk("ready_end", ready_a, 1'b1);
    chk("serial_end", serial_a, 1'b1);
  endtask

  initial begin
    int a0;
    int first_high;
    int next_low;
    int done_k;

    // Reset state
    tick();
    tick();
    chk("rst_serial", serial_a, 1'b1);
    chk("rst_ready", ready_a, 1'b1);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single frame 0xA5
    send_byte(8'hA5);
    watch_frame(-10);
    tick();
    chk("done_one_cycle", done_a, 1'b0);

    // Back-to-back 0x00 then 0xFF with valid held high
    valid_a = 1'b1;
    data_a  = 8'h00;
    tick();
    sb.push_back(8'h00);
    a0 = cyc;
    data_a = 8'hFF;
    watch_frame(-10);
    tick();
    sb.push_back(8'hFF);
    valid_a = 1'b0;
    chk("b2b_period", cyc - a0, 32'd41);
    watch_frame(-10);
    tick();

    // Byte offered mid-frame is ignored
    send_byte(8'h81);
    watch_frame(15);
    for (int i = 0; i < 8; i++) begin
      chk("no_second_frame", serial_a, 1'b1);
      chk("no_second_busy", busy_a, 1'b0);
      tick();
    end
    chk("sb_drained", sb.size(), 32'd0);

    // Reset during d3 of 0xC3 (d3 = 0, so the line is low before reset)
    send_byte(8'hC3);
    for (int k = 0; k < 17; k++) tick();
    chk("pre_rst_d3", serial_a, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_serial", serial_a, 1'b1);
    chk("async_ready", ready_a, 1'b1);
    chk("async_busy", busy_a, 1'b0);
    chk("async_done", done_a, 1'b0);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold_done", done_a, 1'b0);
    end
    valid_a = 1'b1;
    data_a  = 8'h55;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    sb.push_back(8'h55);
    valid_a = 1'b0;
    chk("first_accept_busy", busy_a, 1'b1);
    watch_frame(-10);
    tick();

    // Default 104 clocks per bit, byte 0x01
    chk("b_ready", ready_b, 1'b1);
    valid_b = 1'b1;
    data_b  = 8'h01;
    tick();
    valid_b = 1'b0;
    first_high = -1;
    next_low   = -1;
    done_k     = -1;
    for (int k = 0; k <= 1200; k++) begin
      if (first_high < 0 && serial_b) first_high = k;
      else if (first_high >= 0 && next_low < 0 && !serial_b) next_low = k;
      if (done_b && done_k < 0) done_k = k;
      if (done_k >= 0) break;
      tick();
    end
    chk("b_start_len", first_high, 32'd104);
    chk("b_d0_end", next_low, 32'd208);
    chk("b_done_at", done_k, 32'd1040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 CLKS_PER_BIT, default 104, clock cycles per serial bit (12 MHz / 115200 baud); legal range 4..65535.
REQ-002 clock  input  1  rising-edge clock; sole clock domain.
REQ-003 i_reset_n  input  1  asynchronous active-low reset.
REQ-004 i_tx_data  input  8  byte to transmit; sampled only on accept.
REQ-005 i_tx_valid  input  1  byte on i_tx_data is offered.
REQ-006 o_tx_ready  output  1  block accepts a byte on this edge if i_tx_valid is high.
REQ-007 o_tx_serial  output  1  UART line; idle high.
REQ-008 o_tx_busy  output  1  frame in progress (high from the cycle after accept until the end of the stop bit).
REQ-009 o_tx_done  output  1  single-cycle pulse marking frame completion.

Function
REQ-010 Frame format SHALL be 8N1, LSB first: start bit (0), d0..d7, stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-011 Accept SHALL occur on a rising edge where i_tx_valid=1 and o_tx_ready=1; i_tx_data is latched into an internal shift register on that edge.
REQ-012 After accept, i_tx_data and i_tx_valid SHALL be don't-care until o_tx_ready returns high; there is no buffering, and i_tx_valid while busy is ignored.
REQ-013 State machine SHALL have states IDLE, START, DATA, STOP; o_tx_ready=1 only in IDLE; o_tx_busy=1 in START, DATA, STOP.
REQ-014 IDLE->START on accept; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bits; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-015 Baud counter SHALL be clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1 in every non-IDLE state, reset to 0 on each bit boundary, and hold at 0 in IDLE.
REQ-016 Bit index SHALL be 3 bits, count 0..7 in DATA, and shift the register right one bit per bit boundary.
REQ-017 o_tx_serial SHALL be driven from a register, glitch-free; the start bit appears on the edge of accept (latency 0 cycles after the accepting edge, 1 cycle after valid is sampled).
REQ-018 o_tx_done SHALL pulse high for exactly one cycle, beginning on the STOP->IDLE edge, concurrent with o_tx_ready rising.
REQ-019 With i_tx_valid held high continuously, frames SHALL repeat with a period of 10*CLKS_PER_BIT+1 cycles: one idle-high cycle between the stop bit and the next start bit.
REQ-020 An accept SHALL be possible on the same edge on which o_tx_done is high.

Reset
REQ-021 Assertion of i_reset_n=0 SHALL immediately, without waiting for a clock edge, force: state IDLE, o_tx_serial=1, o_tx_ready=1, o_tx_busy=0, o_tx_done=0, counters 0, shift register 0x00.
REQ-022 Reset mid-frame SHALL abort the frame, with no done pulse; the line returns high at once.
REQ-023 Reset deassertion SHALL be synchronized upstream; the first accept is possible on the first rising edge after release.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-024 Send 0xA5 -> o_tx_serial = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; o_tx_done pulses once, 40 cycles after accept; o_tx_busy high for exactly those 40 cycles.
REQ-025 Back-to-back 0x00 then 0xFF with valid held high -> second start bit begins 41 cycles after the first; the line is high for exactly 1 cycle between frames.
REQ-026 Change i_tx_data to 0x3C and pulse i_tx_valid mid-frame while sending 0x81 -> the frame still carries 0x81; the second byte is not transmitted.
REQ-027 Assert i_reset_n=0 during bit d3 -> o_tx_serial=1 and o_tx_ready=1 before the next clock edge; no o_tx_done; the next byte (0x55) transmits correctly after release.
REQ-028 Default CLKS_PER_BIT=104, send 0x01 -> start bit lasts 104 cycles, d0=1 lasts 104 cycles, and o_tx_done occurs 1040 cycles after accept.
